instruction_fetch: RTL and testbench
====================================

# instruction_fetch

- Fetch stage of the single-issue LEGv8 pipeline: owns the program counter and issues word requests to a 1-cycle-latency instruction memory.
- Buffers returned instructions in a 2-entry queue and presents them to instruction decode with a valid/ready handshake.
- Consumes decode/execute's branch redirect (PCSrc, BranchAddress), flushing queued and in-flight fetches.

## Interface
Parameters:
- RESET_PC, 64'h0, byte address of the first fetch after reset.
- QDEPTH, 2, queue entries; fixed at 2, other values unsupported.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- imem_req  out  1  request strobe; memory accepts every request.
- imem_addr  out  64  byte address of request, bits [1:0] always 0.
- imem_rdata  in  32  instruction word, valid exactly one cycle after the accepted request.
- pc_src  in  1  redirect strobe (PCSrc).
- branch_addr  in  64  redirect target (BranchAddress); bits [1:0] ignored.
- id_valid  out  1  queue head holds a valid instruction.
- id_ready  in  1  decode accepts head this cycle.
- id_instr  out  32  head instruction, drives decode Instruction[31:0].
- id_pc  out  64  byte address of head instruction, drives decode Address.

## Operation
- State:
  - fetch_pc (64b)
  - inflight flag plus inflight address
  - 2-entry queue of {instr, pc} with count 0..2
  - epoch bit
- Handshake: pop when id_valid && id_ready. id_instr/id_pc stable while id_valid && !id_ready.
- Request rule: imem_req = !pc_src && ((count + inflight) < 2 || pop).
  - On request: imem_addr = fetch_pc; inflight set; fetch_pc += 4, wrapping modulo 2^64.
- Response: the cycle after a request, imem_rdata is written into the queue tail at the edge with the inflight address, unless the response was killed.
- Redirect (pc_src=1 sampled at edge):
  - fetch_pc <= {branch_addr[63:2],2'b00}
  - queue count <= 0
  - any in-flight response discarded (epoch toggles; stale response dropped)
  - no imem_req in the redirect cycle
- Redirect and pop in the same cycle: the pop counts as consumed; the flush still clears everything.
- Redirect and response arriving in the same cycle: the response is dropped.
- Queue full and no pop: no request. Overflow is impossible by construction; the bench asserts count ≤ 2.
- Empty queue: id_valid=0; id_instr/id_pc hold their last values (don't-care).

## Timing
- Reset values (rst_n=0 at edge):
  - fetch_pc=RESET_PC
  - count=0, inflight=0, epoch=0
  - id_valid=0, imem_req=0, id_instr=0, id_pc=0
- Reset overrides pc_src and any in-flight response.
- Reset mid-operation: all of the above next cycle; the pending response is discarded.
- Cycle C0 is the first cycle with rst_n=1: imem_req=1, imem_addr=RESET_PC.
  - C1: rdata returns; second request issued.
  - C2: id_valid=1, id_pc=RESET_PC.
- Fetch-to-decode latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle with id_ready held high.
- Redirect penalty: pc_src at edge E leaves id_valid=0 for cycles E+0 and E+1; id_valid=1 with id_pc=target at E+2.
- All outputs are registered except imem_req, which is combinational from count, inflight, pop and pc_src.

## Configuration
- IF_PERF_CNT_EN defined: adds outputs perf_fetched (32b, pops) and perf_redirects (32b, pc_src events).
  - Both counters are saturating at 32'hFFFF_FFFF and reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset release, id_ready=1, memory returns addr-derived words: id_pc = 0,4,8,12 on consecutive cycles from C2; id_instr matches.
- id_ready=0 for 5 cycles after first valid:
  - count reaches 2; imem_req=0.
  - head stays id_pc=0.
  - On release, id_pc = 0,4,8 with no gap or duplicate.
- pc_src=1, branch_addr=64'h103 while streaming: id_valid low 2 cycles, then id_pc=64'h100; the pre-redirect in-flight word never appears.
- pc_src with simultaneous pop and arriving response: the popped instruction is counted once; the response is dropped; the next id_pc is the target.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFF8, id_ready=1: id_pc = ...FFF8, ...FFFC, 0, 4 (wrap).
- With IF_PERF_CNT_EN: 10 pops and 3 redirects give perf_fetched=10, perf_redirects=3; rst_n low clears both to 0.

Source files
------------

// File: rtl/instruction_fetch.sv
// LEGv8 fetch stage: PC, 1-cycle instruction memory requests, 2-entry decode queue.
// Optional IF_PERF_CNT_EN adds saturating pop/redirect counters.
module instruction_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [63:0] branch_addr,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
`ifdef IF_PERF_CNT_EN
    output logic [63:0] id_pc,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_redirects
`else
    output logic [63:0] id_pc
`endif
);

    localparam logic [2:0]  QD       = 3'(QDEPTH);
    localparam logic [63:0] ALIGN_PC = RESET_PC & ~64'h3;

    logic [63:0] fetch_pc;
    logic        inflight;
    logic [63:0] inflight_pc;
    logic        inflight_epoch;
    logic        epoch;
    logic [1:0]  count;
    logic [1:0]  count_next;
    logic [31:0] tail_instr;
    logic [63:0] tail_pc;
    logic        pop;
    logic        push;

    assign imem_addr = fetch_pc;

    always_comb begin
        pop        = id_valid && id_ready;
        // A response issued in an older epoch, or landing on a redirect, is dropped.
        push       = inflight && (inflight_epoch == epoch) && !pc_src;
        imem_req   = rst_n && !pc_src &&
                     ((({1'b0, count} + {2'b00, inflight}) < QD) || pop);
        count_next = count;
        case ({pop, push})
            2'b10:   count_next = count - 2'd1;
            2'b01:   count_next = count + 2'd1;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc       <= ALIGN_PC;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
            count          <= '0;
            id_valid       <= 1'b0;
            id_instr       <= '0;
            id_pc          <= '0;
            tail_instr     <= '0;
            tail_pc        <= '0;
        end else if (pc_src) begin
            fetch_pc <= branch_addr & ~64'h3;
            inflight <= 1'b0;
            epoch    <= ~epoch;
            count    <= '0;
            id_valid <= 1'b0;
        end else begin
            if (imem_req) begin
                fetch_pc       <= fetch_pc + 64'd4;
                inflight       <= 1'b1;
                inflight_pc    <= fetch_pc;
                inflight_epoch <= epoch;
            end else begin
                inflight <= 1'b0;
            end
            // Head lives directly in the id_* output registers; tail is the second slot.
            case ({pop, push})
                2'b11: begin
                    if (count == 2'd1) begin
                        id_instr <= imem_rdata;
                        id_pc    <= inflight_pc;
                    end else begin
                        id_instr   <= tail_instr;
                        id_pc      <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= inflight_pc;
                    end
                end
                2'b10: begin
                    id_instr <= tail_instr;
                    id_pc    <= tail_pc;
                end
                2'b01: begin
                    if (count == 2'd0) begin
                        id_instr <= imem_rdata;
                        id_pc    <= inflight_pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= inflight_pc;
                    end
                end
                default: ;
            endcase
            count    <= count_next;
            id_valid <= (count_next != 2'd0);
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (pop && (perf_fetched != '1))
                perf_fetched <= perf_fetched + 32'd1;
            if (pc_src && (perf_redirects != '1))
                perf_redirects <= perf_redirects + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, streaming, stall, redirect, PC wrap, perf counters.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_ready;
    logic        pc_src;
    logic [63:0] branch_addr;
    logic        imem_req, req2;
    logic [63:0] imem_addr, addr2;
    logic [31:0] imem_rdata, rdata2;
    logic        id_valid, valid2;
    logic [31:0] id_instr, instr2;
    logic [63:0] id_pc, pc2;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_redirects, p2f, p2r;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    instruction_fetch #(.RESET_PC(64'h0), .QDEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_src(pc_src), .branch_addr(branch_addr),
        .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
`ifdef IF_PERF_CNT_EN
        .id_pc(id_pc), .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`else
        .id_pc(id_pc)
`endif
    );

    instruction_fetch #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .QDEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(req2), .imem_addr(addr2),
        .imem_rdata(rdata2), .pc_src(pc_src), .branch_addr(branch_addr),
        .id_valid(valid2), .id_ready(id_ready), .id_instr(instr2),
`ifdef IF_PERF_CNT_EN
        .id_pc(pc2), .perf_fetched(p2f), .perf_redirects(p2r)
`else
        .id_pc(pc2)
`endif
    );

    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ 32'h5A00_0000;
    endfunction

    // 1-cycle memory: data for the request seen at an edge is present the following cycle.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? word_of(imem_addr) : 32'hBAD0_BAD0;
        rdata2     <= req2 ? word_of(addr2) : 32'hBAD0_BAD0;
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && dut.count > 2'd2) begin
            failed++;
            $display("FAIL queue_count: got %0d, limit 2", dut.count);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle C0 (first cycle with rst_n=1), inputs idle.
    task automatic do_reset();
        rst_n = 1'b0; pc_src = 1'b0; id_ready = 1'b0; branch_addr = '0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc_src = 1'b1; id_ready = 1'b1; branch_addr = 64'h200;
        tick();
        tick();
        #1;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b exp 0", id_valid); end
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL reset_req: got %b exp 0", imem_req); end
        tests++; if (id_pc !== 64'h0) begin failed++; $display("FAIL reset_pc: got %h exp 0", id_pc); end
        tests++; if (id_instr !== 32'h0) begin failed++; $display("FAIL reset_instr: got %h exp 0", id_instr); end
        pc_src = 1'b0; id_ready = 1'b0; rst_n = 1'b1;
        #1;
        tests++; if (imem_req !== 1'b1) begin failed++; $display("FAIL c0_req: got %b exp 1", imem_req); end
        tests++; if (imem_addr !== 64'h0) begin failed++; $display("FAIL c0_addr: got %h exp 0", imem_addr); end
    endtask

    task automatic test_stream();
        do_reset();
        id_ready = 1'b1;
        #1;
        tick();
        tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin failed++; $display("FAIL c1_req: got %b/%h exp 1/4", imem_req, imem_addr); end
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL c1_valid: got %b exp 0", id_valid); end
        for (int k = 0; k < 4; k++) begin
            logic [63:0] exp_pc;
            tick();
            exp_pc = 64'(4 * k);
            tests++; if (id_valid !== 1'b1 || id_pc !== exp_pc) begin failed++; $display("FAIL stream_pc%0d: got %b/%h exp 1/%h", k, id_valid, id_pc, exp_pc); end
            tests++; if (id_instr !== word_of(exp_pc)) begin failed++; $display("FAIL stream_instr%0d: got %h exp %h", k, id_instr, word_of(exp_pc)); end
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            tests++; if (id_valid !== 1'b1 || id_pc !== 64'h0) begin failed++; $display("FAIL stall_head%0d: got %b/%h exp 1/0", i, id_valid, id_pc); end
            if (i >= 1) begin
                tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL stall_req%0d: got %b exp 0", i, imem_req); end
                tests++; if (dut.count !== 2'd2) begin failed++; $display("FAIL stall_count%0d: got %0d exp 2", i, dut.count); end
            end
            tick();
        end
        id_ready = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            logic [63:0] exp_pc;
            exp_pc = 64'(4 * k);
            tests++; if (id_valid !== 1'b1 || id_pc !== exp_pc || id_instr !== word_of(exp_pc)) begin failed++; $display("FAIL release_pc%0d: got %b/%h exp 1/%h", k, id_valid, id_pc, exp_pc); end
            tick();
        end
    endtask

    // Redirect at C4 coincides with a pop (pc 8) and the response for pc 12.
    task automatic test_redirect();
        do_reset();
        id_ready = 1'b1;
        tick(); tick(); tick(); tick();
        tests++; if (id_pc !== 64'h8) begin failed++; $display("FAIL pre_redirect_pc: got %h exp 8", id_pc); end
        pc_src = 1'b1; branch_addr = 64'h103;
        #1;
        tests++; if (imem_req !== 1'b0) begin failed++; $display("FAIL redirect_req: got %b exp 0", imem_req); end
        tick();
        pc_src = 1'b0; branch_addr = '0;
        #1;
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL redirect_e0: got %b exp 0", id_valid); end
        tests++; if (imem_req !== 1'b1 || imem_addr !== 64'h100) begin failed++; $display("FAIL redirect_fetch: got %b/%h exp 1/100", imem_req, imem_addr); end
        tick();
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL redirect_e1: got %b exp 0", id_valid); end
        tick();
        tests++; if (id_valid !== 1'b1 || id_pc !== 64'h100 || id_instr !== word_of(64'h100)) begin failed++; $display("FAIL redirect_target: got %b/%h exp 1/100", id_valid, id_pc); end
        tick();
        tests++; if (id_valid !== 1'b1 || id_pc !== 64'h104) begin failed++; $display("FAIL redirect_next: got %b/%h exp 1/104", id_valid, id_pc); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        id_ready = 1'b1;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        tests++; if (id_valid !== 1'b0 || id_pc !== 64'h0 || imem_req !== 1'b0) begin failed++; $display("FAIL midreset: got %b/%h/%b exp 0/0/0", id_valid, id_pc, imem_req); end
        rst_n = 1'b1;
        #1;
        tests++; if (imem_addr !== 64'h0) begin failed++; $display("FAIL midreset_addr: got %h exp 0", imem_addr); end
        tick();
        tests++; if (id_valid !== 1'b0) begin failed++; $display("FAIL midreset_c1: got %b exp 0", id_valid); end
        tick();
        tests++; if (id_valid !== 1'b1 || id_pc !== 64'h0) begin failed++; $display("FAIL midreset_c2: got %b/%h exp 1/0", id_valid, id_pc); end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_pcs [4];
        exp_pcs[0] = 64'hFFFF_FFFF_FFFF_FFF8;
        exp_pcs[1] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_pcs[2] = 64'h0;
        exp_pcs[3] = 64'h4;
        do_reset();
        id_ready = 1'b1;
        #1;
        tests++; if (req2 !== 1'b1 || addr2 !== exp_pcs[0]) begin failed++; $display("FAIL wrap_c0: got %b/%h exp 1/%h", req2, addr2, exp_pcs[0]); end
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            tests++; if (valid2 !== 1'b1 || pc2 !== exp_pcs[k] || instr2 !== word_of(exp_pcs[k])) begin failed++; $display("FAIL wrap_pc%0d: got %b/%h exp 1/%h", k, valid2, pc2, exp_pcs[k]); end
        end
    endtask

`ifdef IF_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        tests++; if (perf_fetched !== 32'd0 || perf_redirects !== 32'd0) begin failed++; $display("FAIL perf_reset: got %0d/%0d exp 0/0", perf_fetched, perf_redirects); end
        id_ready = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        id_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pc_src = (i % 2 == 0);
            branch_addr = 64'h400;
            tick();
        end
        pc_src = 1'b0;
        tick();
        tests++; if (perf_fetched !== 32'd10) begin failed++; $display("FAIL perf_fetched: got %0d exp 10", perf_fetched); end
        tests++; if (perf_redirects !== 32'd3) begin failed++; $display("FAIL perf_redirects: got %0d exp 3", perf_redirects); end
        rst_n = 1'b0;
        tick();
        tests++; if (perf_fetched !== 32'd0 || perf_redirects !== 32'd0) begin failed++; $display("FAIL perf_clear: got %0d/%0d exp 0/0", perf_fetched, perf_redirects); end
        rst_n = 1'b1;
    endtask
`endif

    initial begin
        rst_n = 1'b0; pc_src = 1'b0; id_ready = 1'b0; branch_addr = '0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_reset_mid();
        test_wrap();
`ifdef IF_PERF_CNT_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
